piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: accepts an N-bit word over a valid/ready
//  handshake and shifts it out one bit per Clock on Q, with a Frame qualifier.
//  Transmit end of the serial shift-register link: its Q drives the D input of
//  the serial-in/parallel-out receiver, which holds the word after N clocks.
// PARAMETERS
//  N          10  word width in bits (N >= 2)
//  MSB_FIRST  1   1: send Data_In[N-1] first (matches receiver shifting toward MSB); 0: LSB first
// PORTS
//  Clock       in   1   system clock; all state updates on posedge
//  Resetn      in   1   asynchronous, active-low reset
//  Data_In     in   N   parallel word to transmit
//  Load_Valid  in   1   Data_In valid
//  Load_Ready  out  1   serializer can accept a word this cycle
//  Q           out  1   serial data out (registered)
//  Frame       out  1   high on every cycle Q carries a valid data bit
//  Done        out  1   one-cycle pulse coincident with last bit of a word
// BEHAVIOUR
//  - One clock (Clock); reset is asynchronous and active-low (Resetn).
//  - Reset (Resetn=0, immediate): state=S_IDLE, shift reg=0, count=0,
//    Q=0, Frame=0, Done=0, Load_Ready=1 after release.
//  - Accept = Load_Valid & Load_Ready, sampled at posedge.
//  - FSM S_IDLE: Load_Ready=1, Frame=0, Q=0. On accept: load word,
//    Q<=first bit, Frame<=1, count<=N-1, go S_SHIFT.
//  - FSM S_SHIFT: each posedge shift by one (toward MSB if MSB_FIRST=1,
//    toward LSB otherwise), Q<=next bit, count<=count-1.
//  - Last-bit cycle (S_SHIFT, count==0): Done=1, Load_Ready=1.
//    Accept here -> new word's first bit on Q next cycle, Frame stays 1
//    (gapless back-to-back). No accept -> go S_IDLE, Frame<=0, Q<=0.
//  - Load_Ready=0 in S_SHIFT with count!=0; Load_Valid ignored there,
//    Data_In not sampled.
//  - Latency: first bit on Q the cycle after accept; word occupies exactly
//    N consecutive Frame cycles; throughput 1 word / N cycles max.
//  - Done, Frame, Load_Ready are combinational from registered state only
//    (no input-to-output paths); Q is a flop.
//  - Counter width $clog2(N); never wraps below 0 (reload or idle at 0).
//  - Resetn asserted mid-frame: frame aborted, no Done, partial word lost;
//    resumes in S_IDLE with Load_Ready=1.
//  - Data_In changes after accept have no effect on the word in flight.
// STRUCTURE
//  - Package sr_pkg: typedef enum logic {S_IDLE, S_SHIFT} sr_state_t;
//    localparam helpers for count width; shared with the receiver bench.
//  - One sub-module: sr_bit_counter (loadable down-counter, terminal flag
//    tc=(count==0)). Shift register and FSM live in piso_serializer.
// TESTING
//  1 Reset: Resetn=0 mid-random traffic -> Q=0, Frame=0, Done=0 at once;
//    Load_Ready=1 first cycle after release.
//  2 Single word N=10, MSB_FIRST=1, Data_In=10'b0001110111 -> Q on cycles
//    1..10 = 0,0,0,1,1,1,0,1,1,1; Frame=1 cycles 1..10; Done only cycle 10.
//  3 Back-to-back: words 10'h3FF then 10'h000, Load_Valid held high ->
//    20 contiguous Frame cycles, Done at 10 and 20, Load_Ready=0 on 1..9.
//  4 MSB_FIRST=0, Data_In=10'b0000000001 -> Q=1 on cycle 1, 0 on 2..10.
//  5 Reset mid-frame: assert Resetn=0 after bit 4 -> no Done; next word
//    10'h155 transmits fully and correctly.
//  6 Loopback: Q into the 10-bit SIPO receiver D; after each Done the
//    receiver's parallel register equals the sent word (500 random words).

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// sr_pkg: shared FSM state type and counter-width helper for the serial shift-register link
package sr_pkg;
  typedef enum logic {S_IDLE, S_SHIFT} sr_state_t;
  localparam int N_DEF = 10;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial output bundle of the serializer
interface piso_serializer_if #(parameter int N = 10);
  logic [N-1:0] Data_In;
  logic Load_Valid;
  logic Load_Ready;
  logic Q;
  logic Frame;
  logic Done;
  modport master (output Data_In, Load_Valid, input Load_Ready, Q, Frame, Done);
  modport slave (input Data_In, Load_Valid, output Load_Ready, Q, Frame, Done);
endinterface

// File: rtl/sr_bit_counter.sv
// sr_bit_counter: loadable down-counter that parks at zero and flags it with tc
module sr_bit_counter #(parameter int W = 4) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc
);
  assign tc = count == '0;
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) count <= '0;
    else count <= load ? load_val : (dec && !tc) ? count - 1'b1 : count;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded parallel-in/serial-out transmitter with Frame and Done
module piso_serializer import sr_pkg::*; #(
  parameter int N = N_DEF,
  parameter int MSB_FIRST = 1
) (
  input logic Clock,
  input logic Resetn,
  piso_serializer_if.slave bus
);
  localparam int W = cnt_w(N);
  sr_state_t state, state_nx;
  logic [N-1:0] sreg, sreg_nx;
  logic q, q_nx, tc, accept;
  logic [W-1:0] count;
  assign bus.Frame = state == S_SHIFT;
  assign bus.Done = bus.Frame && tc;
  assign bus.Load_Ready = !bus.Frame || tc;
  assign bus.Q = q;
  assign accept = bus.Load_Valid && bus.Load_Ready;
  sr_bit_counter #(.W(W)) u_cnt (
    .Clock(Clock), .Resetn(Resetn), .load(accept), .load_val(W'(N - 1)),
    .dec(bus.Frame), .count(count), .tc(tc)
  );
  // sreg always holds the bit currently on Q at its outgoing end
  always_comb begin
    state_nx = state;
    sreg_nx = sreg;
    q_nx = q;
    if (accept) begin
      state_nx = S_SHIFT;
      sreg_nx = bus.Data_In;
      q_nx = (MSB_FIRST != 0) ? bus.Data_In[N-1] : bus.Data_In[0];
    end else if (bus.Done) begin
      state_nx = S_IDLE;
      q_nx = 1'b0;
    end else if (bus.Frame) begin
      sreg_nx = (MSB_FIRST != 0) ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};
      q_nx = (MSB_FIRST != 0) ? sreg[N-2] : sreg[1];
    end
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state <= S_IDLE;
      sreg <= '0;
      q <= 1'b0;
    end else begin
      state <= state_nx;
      sreg <= sreg_nx;
      q <= q_nx;
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for MSB-first and LSB-first serializers with a SIPO receiver model
module tb_piso_serializer;
  logic Clock, Resetn;
  logic [9:0] din [2];
  logic vld [2];
  logic q [2], frame [2], done [2], rdy [2];
  bit bq [2][$];
  logic [9:0] wq [2][$];
  logic [9:0] rx [2];
  int idx [2];
  int checks = 0, errors = 0;

  piso_serializer_if #(.N(10)) b0 ();
  piso_serializer_if #(.N(10)) b1 ();
  piso_serializer #(.N(10), .MSB_FIRST(1)) dut0 (.Clock(Clock), .Resetn(Resetn), .bus(b0.slave));
  piso_serializer #(.N(10), .MSB_FIRST(0)) dut1 (.Clock(Clock), .Resetn(Resetn), .bus(b1.slave));

  assign b0.Data_In = din[0];
  assign b0.Load_Valid = vld[0];
  assign b1.Data_In = din[1];
  assign b1.Load_Valid = vld[1];
  assign q[0] = b0.Q;
  assign frame[0] = b0.Frame;
  assign done[0] = b0.Done;
  assign rdy[0] = b0.Load_Ready;
  assign q[1] = b1.Q;
  assign frame[1] = b1.Frame;
  assign done[1] = b1.Done;
  assign rdy[1] = b1.Load_Ready;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // receiver model and scoreboard, sampled mid-cycle
  always @(negedge Clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!Resetn) begin
        check("rst_q", q[k], 0);
        check("rst_frame", frame[k], 0);
        check("rst_done", done[k], 0);
        bq[k].delete();
        wq[k].delete();
        idx[k] = 0;
        rx[k] = '0;
      end else begin
        if (frame[k]) begin
          if (bq[k].size() == 0) check("frame_unexpected", frame[k], 0);
          else check("q_bit", q[k], bq[k].pop_front());
          rx[k] = (k == 0) ? {rx[k][8:0], q[k]} : {q[k], rx[k][9:1]};
          check("done", done[k], idx[k] == 9);
          check("ready_busy", rdy[k], idx[k] == 9);
          if (done[k]) begin
            if (wq[k].size() == 0) check("word_unexpected", done[k], 0);
            else check("rx_word", rx[k], wq[k].pop_front());
          end
          idx[k] = (idx[k] == 9) ? 0 : idx[k] + 1;
        end else begin
          check("idle_q", q[k], 0);
          check("idle_done", done[k], 0);
          check("idle_ready", rdy[k], 1);
          check("frame_gap", bq[k].size(), 0);
          idx[k] = 0;
        end
        if (vld[k] && rdy[k]) begin
          wq[k].push_back(din[k]);
          for (int i = 0; i < 10; i++) bq[k].push_back(k == 0 ? din[k][9-i] : din[k][i]);
        end
      end
    end
  end

  task automatic send(input int k, input logic [9:0] w);
    int n;
    n = 0;
    din[k] = w;
    vld[k] = 1'b1;
    @(negedge Clock);
    while (!rdy[k] && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check("ready_wait", rdy[k], 1);
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    din[0] = 10'($urandom);
    din[1] = 10'($urandom);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic async_reset();
    @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("async_q", q[0], 0);
    check("async_frame", frame[0], 0);
    check("async_done", done[0], 0);
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    @(negedge Clock);
    check("ready_after_rst", rdy[0], 1);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0;
    din[0] = '0;
    din[1] = '0;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;
    idle(2);
    din[0] = 10'($urandom);
    din[1] = 10'($urandom);
    vld[0] = 1'b1;
    vld[1] = 1'b1;
    repeat (5) @(posedge Clock);
    async_reset();
    idle(2);
    send(0, 10'b0001110111);
    idle(14);
    send(0, 10'h3FF);
    send(0, 10'h000);
    idle(14);
    send(1, 10'b0000000001);
    idle(14);
    send(0, 10'($urandom));
    vld[0] = 1'b0;
    repeat (3) @(posedge Clock);
    async_reset();
    send(0, 10'h155);
    idle(14);
    for (int i = 0; i < 100; i++) send(1, 10'($urandom));
    idle(14);
    for (int i = 0; i < 500; i++) begin
      send(0, 10'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        vld[0] = 1'b0;
        din[0] = 10'($urandom);
        repeat ($urandom_range(1, 12)) @(posedge Clock);
        #1;
      end
    end
    idle(15);
    check("sb_bits0", bq[0].size(), 0);
    check("sb_words0", wq[0].size(), 0);
    check("sb_bits1", bq[1].size(), 0);
    check("sb_words1", wq[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
